seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Parametrised successor to the board-level display path: converts NUM_CH unsigned binary channels (register-file or data-memory probes from the core) into decimal digits with a sequential double-dabble engine and drives NUM_CH×DIGITS active-low 7-segment digits. Refresh is periodic via an internal prescaler, or on demand via a request strobe. Outputs are double-buffered and change atomically. Sits between the RISC-V core debug taps and the board HEX pins; replaces per-digit combinational BCD wiring.

## Interface
- NUM_CH, 4: number of channels displayed.
- DATA_W, 8: width of each channel value, unsigned; minimum 4.
- DIGITS, 2: decimal digits shown per channel; minimum 1.
- TICK_DIV, 5_000_000: clk cycles per automatic refresh; minimum 2*NUM_CH*(DATA_W+2).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; one clock domain.
- ch_data  in  NUM_CH*DATA_W  channel values, channel 0 in LSBs.
- update_req  in  1  single-cycle strobe requesting immediate refresh.
- seg  out  NUM_CH*DIGITS*7  active-low segments {g,f,e,d,c,b,a} per digit; channel 0 units digit in bits [6:0], tens in [13:7], and so on.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when seg updates.
- heartbeat  out  1  toggles on every prescaler tick (LED).

## Operation
- FSM: IDLE, LOAD, SHIFT, STORE. IDLE->LOAD when a refresh trigger (tick, update_req, or pending flag) is present.
- First LOAD of a refresh snapshots all of ch_data; later channels use the snapshot, so mid-refresh input changes are ignored.
- LOAD: clear BCD accumulator (4*ceil(DATA_W/3) bits), load channel value, set bit counter to DATA_W. SHIFT: for DATA_W cycles, add 3 to every BCD nibble ≥5, then shift left one bit. STORE: write DIGITS nibbles into shadow buffer; overflow if any higher nibble is non-zero; then next channel LOAD, or after channel NUM_CH-1 commit shadow to seg, pulse done, return IDLE.
- Overflow channel: all its digits show '-' (7'h3F).
- Digit encodings: 0=7'h40, 2=7'h24, 4=7'h19, 7=7'h78, 9=7'h10, blank=7'h7F, '-'=7'h3F.
- Trigger arriving while busy (tick or update_req): set one pending flag; multiple triggers collapse into one extra refresh, started the cycle after commit.
- Prescaler free-runs 0..TICK_DIV-1 independent of FSM; tick on wrap.

## Timing
- Reset (reset=0 at an edge): seg all 7'h7F, busy 0, done 0, heartbeat 0, pending 0, prescaler 0, FSM IDLE. Reset mid-conversion aborts; shadow discarded.
- update_req sampled high at edge k (IDLE): busy=1 from k+1; seg and done change at edge k+1+NUM_CH*(DATA_W+2); busy=0 at that same edge.
- done high exactly one cycle; seg stable otherwise.
- heartbeat toggles on the edge the prescaler wraps; first toggle TICK_DIV cycles after reset release.

## Configuration
- DISP_LZ_BLANK_EN defined: leading zero digits of a non-overflow channel show blank (7'h7F); units digit always shown (value 0 shows '0'). Not defined: all DIGITS digits shown including leading zeros. Overflow dashes are unaffected.

## Structure
- Package seg_display_pkg: FSM state enum, segment constants (SEG_BLANK, SEG_DASH, digit table), function returning 7-bit pattern for a nibble.
- Sub-module bin2bcd_seq: LOAD/SHIFT datapath (value register, BCD accumulator, bit counter, start/finish handshake); top holds FSM sequencing, snapshot, shadow/seg buffers, prescaler, pending flag.

## Test plan
- Reset: hold reset=0 three cycles with ch_data nonzero -> seg all 7'h7F, busy=0, done=0, heartbeat=0.
- NUM_CH=2, DATA_W=8, DIGITS=2: ch0=42, ch1=7, update_req at edge k -> done at k+21; ch0 digits {0x19,0x24}; ch1 {0x40,0x78} (without macro) or {0x7F,0x78} (with DISP_LZ_BLANK_EN).
- Overflow: ch0=255, ch1=99 -> ch0 both digits 7'h3F, ch1 {0x10,0x10}.
- Collision: update_req at k, again at k+5 and k+9, ch_data changed at k+3 -> first commit shows data sampled at k+1; exactly one extra refresh, second done 21 cycles after first.
- Reset mid-refresh at k+10 -> seg 7'h7F, busy=0 next cycle, no done pulse.
- TICK_DIV=50, no update_req -> heartbeat toggles every 50 cycles; refresh starts each tick; done count equals tick count.

Source files
------------

// File: rtl/seg_display_pkg.sv
// seg_display_pkg
//   Shared definitions for the seven-segment display controller:
//   FSM state encoding, active-low segment patterns {g,f,e,d,c,b,a},
//   and a nibble-to-pattern helper.
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-decimal nibbles cannot come out of the converter; show blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return SEG_DIGIT[nib];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if
//   Bundle between the debug taps / board pins and seg_display_ctrl.
//   ch_data    : NUM_CH*DATA_W channel values, channel 0 in LSBs
//   update_req : single-cycle refresh request strobe
//   seg        : NUM_CH*DIGITS*7 active-low segments, ch0 units in [6:0]
//   busy       : conversion in progress
//   done       : one-cycle pulse when seg updates
//   heartbeat  : toggles on every prescaler tick
//   master drives the channel data and requests; slave is the controller.
interface seg_display_ctrl_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 2
);

    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic                       update_req;
    logic [NUM_CH*DIGITS*7-1:0] seg;
    logic                       busy;
    logic                       done;
    logic                       heartbeat;

    modport master (
        output ch_data,
        output update_req,
        input  seg,
        input  busy,
        input  done,
        input  heartbeat
    );

    modport slave (
        input  ch_data,
        input  update_req,
        output seg,
        output busy,
        output done,
        output heartbeat
    );

endinterface

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter, one bit per clock.
//   clk    : system clock
//   reset  : synchronous, active-low
//   start  : load value, clear accumulator, arm DATA_W shifts
//   value  : unsigned binary input, sampled when start is high
//   bcd    : BCD accumulator, nibble 0 is units; stable once shifting ends
//   finish : high in the cycle whose closing edge performs the last shift
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BCD_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic [BCD_W-1:0]  bcd,
    output logic              finish
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] val_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            val_q <= value;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], val_q[DATA_W-1]};
            val_q <= val_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bcd    = bcd_q;
    assign finish = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
//   Converts NUM_CH unsigned channels to decimal and drives NUM_CH*DIGITS
//   active-low seven-segment digits. Refresh runs on every prescaler tick
//   or on update_req; triggers during a refresh collapse into one pending
//   refresh. Results collect in a shadow buffer and are committed to seg
//   atomically together with a one-cycle done pulse.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : seg_display_ctrl_if.slave (ch_data, update_req in;
//           seg, busy, done, heartbeat out)
//   Build option DISP_LZ_BLANK_EN: blank leading zero digits of
//   non-overflow channels (units digit always shown).
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    seg_display_ctrl_if.slave bus
);

    localparam int unsigned BCD_NIB  = (DATA_W + 2) / 3;
    localparam int unsigned BCD_W    = 4 * BCD_NIB;
    localparam int unsigned EXT_NIB  = (BCD_NIB > DIGITS) ? BCD_NIB : DIGITS;
    localparam int unsigned EXT_W    = 4 * EXT_NIB;
    localparam int unsigned SEG_CH_W = 7 * DIGITS;
    localparam int unsigned SEG_W    = NUM_CH * SEG_CH_W;
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PS_W     = $clog2(TICK_DIV);

    state_e                   state_q;
    logic [CH_W-1:0]          ch_idx_q;
    logic [NUM_CH*DATA_W-1:0] snap_q;
    logic [SEG_W-1:0]         shadow_q;
    logic [SEG_W-1:0]         seg_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     hb_q;
    logic                     pend_q;
    logic                     commit_q;
    logic [PS_W-1:0]          ps_q;

    logic                     tick;
    logic                     trig;
    logic                     eng_start;
    logic [DATA_W-1:0]        eng_value;
    logic [BCD_W-1:0]         eng_bcd;
    logic                     eng_finish;

    logic [EXT_W-1:0]         ext;
    logic                     ovf;
    int unsigned              d;
    logic [3:0]               nib;
    logic [6:0]               pat;
    logic [SEG_CH_W-1:0]      digit_pat;
`ifdef DISP_LZ_BLANK_EN
    logic                     lead;
`endif

    assign tick = (ps_q == PS_W'(TICK_DIV - 1));
    assign trig = tick | bus.update_req;

    // Channel 0 converts straight from the live input in the same cycle the
    // snapshot is taken, so every channel of a refresh sees one instant.
    assign eng_start = (state_q == ST_LOAD);
    assign eng_value = (ch_idx_q == '0) ? bus.ch_data[DATA_W-1:0]
                                        : snap_q[ch_idx_q*DATA_W +: DATA_W];

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .BCD_W  (BCD_W)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .value  (eng_value),
        .bcd    (eng_bcd),
        .finish (eng_finish)
    );

    // Digit patterns for the channel currently held in the converter.
    always_comb begin
        ext                = '0;
        ext[BCD_W-1:0]     = eng_bcd;
        ovf                = 1'b0;
        d                  = 0;
        nib                = '0;
        pat                = SEG_BLANK;
        digit_pat          = '0;
`ifdef DISP_LZ_BLANK_EN
        lead               = 1'b1;
`endif
        for (int unsigned i = DIGITS; i < EXT_NIB; i++) begin
            if (ext[i*4 +: 4] != 4'd0) begin
                ovf = 1'b1;
            end
        end
        // Walk from the most significant shown digit down so that leading
        // zeros can be identified.
        for (int unsigned k = 0; k < DIGITS; k++) begin
            d   = DIGITS - 1 - k;
            nib = ext[d*4 +: 4];
`ifdef DISP_LZ_BLANK_EN
            if (lead && (nib == 4'd0) && (d != 0)) begin
                pat = SEG_BLANK;
            end else begin
                lead = 1'b0;
                pat  = seg_encode(nib);
            end
`else
            pat = seg_encode(nib);
`endif
            digit_pat[d*7 +: 7] = ovf ? SEG_DASH : pat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            snap_q   <= '0;
            shadow_q <= '1;
            seg_q    <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hb_q     <= 1'b0;
            pend_q   <= 1'b0;
            commit_q <= 1'b0;
            ps_q     <= '0;
        end else begin
            done_q <= 1'b0;
            ps_q   <= tick ? '0 : ps_q + PS_W'(1);
            if (tick) begin
                hb_q <= ~hb_q;
            end

            if (trig && (state_q != ST_IDLE)) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // The commit happens one cycle after the last STORE,
                    // once the shadow holds every channel; busy covers it.
                    if (commit_q) begin
                        commit_q <= 1'b0;
                        seg_q    <= shadow_q;
                        done_q   <= 1'b1;
                        if (pend_q || trig) begin
                            state_q <= ST_LOAD;
                            pend_q  <= 1'b0;
                        end else begin
                            busy_q <= 1'b0;
                        end
                    end else if (trig || pend_q) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ch_idx_q == '0) begin
                        snap_q <= bus.ch_data;
                    end
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (eng_finish) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    shadow_q[ch_idx_q*SEG_CH_W +: SEG_CH_W] <= digit_pat;
                    if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
                        ch_idx_q <= '0;
                        commit_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        ch_idx_q <= ch_idx_q + CH_W'(1);
                        state_q  <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.seg       = seg_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.heartbeat = hb_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl
//   Two instances: dut_a (prescaler too long to tick during the run) takes
//   directed update_req refreshes; dut_b (TICK_DIV=50) refreshes from its
//   prescaler only. Expected seg values and done cycles are queued when a
//   trigger is driven and checked when done pulses.
module tb_seg_display_ctrl;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DIGITS  = 2;
    localparam int unsigned TICK_A  = 60000;
    localparam int unsigned TICK_B  = 50;
    localparam int          LAT     = 1 + NUM_CH * (DATA_W + 2);
    localparam int          END_CYC = 633;

    localparam logic [6:0] ENC [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct {
        logic [27:0] seg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_a_q = 1'b0;
    logic rst_b_q = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [27:0] seg_ref_a = '1;
    int   hb_cnt = 0;
    int   done_b_cnt = 0;
    int   next_hb = 0;
    logic hb_prev = 1'b0;

    always #5 clk = ~clk;

    seg_display_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus_a ();
    seg_display_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS)) bus_b ();

    seg_display_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS), .TICK_DIV(TICK_A)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    seg_display_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIGITS(DIGITS), .TICK_DIV(TICK_B)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    function automatic logic [13:0] ch_pat(input int v);
        logic [6:0] hi;
        if (v >= 100) begin
            return {7'h3F, 7'h3F};
        end
        hi = ENC[v / 10];
`ifdef DISP_LZ_BLANK_EN
        if (v < 10) begin
            hi = 7'h7F;
        end
`endif
        return {hi, ENC[v % 10]};
    endfunction

    function automatic logic [27:0] exp_seg(input int v0, input int v1);
        return {ch_pat(v1), ch_pat(v0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_a_q = rst_a;
        rst_b_q = rst_b;
    end

    // Scoreboard for dut_a: every done must match the queue head; seg must
    // not move between done pulses.
    always @(negedge clk) begin
        if (!rst_a_q) begin
            q_a.delete();
            seg_ref_a = '1;
            chk("a_reset_seg", 64'(bus_a.seg), 64'(seg_ref_a));
            chk("a_reset_done", 64'(bus_a.done), 64'(0));
        end else if (bus_a.done) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 64'(cyc), 64'(0));
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_done_cycle", 64'(cyc), 64'(e.cyc));
                chk("a_seg", 64'(bus_a.seg), 64'(e.seg));
                seg_ref_a = e.seg;
            end
        end else begin
            chk("a_seg_stable", 64'(bus_a.seg), 64'(seg_ref_a));
        end
    end

    // dut_b: each heartbeat toggle is a tick, which must start one refresh.
    always @(negedge clk) begin
        if (!rst_b_q) begin
            next_hb = cyc + TICK_B;
            hb_prev = 1'b0;
            q_b.delete();
        end else begin
            if (bus_b.heartbeat !== hb_prev) begin
                hb_cnt++;
                chk("b_hb_cycle", 64'(cyc), 64'(next_hb));
                next_hb = next_hb + TICK_B;
                hb_prev = bus_b.heartbeat;
                q_b.push_back('{exp_seg(3, 160), cyc + LAT});
            end
            if (bus_b.done) begin
                done_b_cnt++;
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done", 64'(cyc), 64'(0));
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("b_seg", 64'(bus_b.seg), 64'(e.seg));
                end
            end
        end
    end

    task automatic refresh_a(input int v0, input int v1);
        bus_a.ch_data    = {8'(v1), 8'(v0)};
        bus_a.update_req = 1'b1;
        q_a.push_back('{exp_seg(v0, v1), cyc + 1 + LAT});
        step();
        bus_a.update_req = 1'b0;
        @(negedge clk);
        chk("a_busy_started", 64'(bus_a.busy), 64'(1));
        repeat (LAT + 2) step();
        @(negedge clk);
        chk("a_busy_cleared", 64'(bus_a.busy), 64'(0));
    endtask

    initial begin
        int k;
        bus_a.ch_data    = {8'd7, 8'd42};
        bus_a.update_req = 1'b0;
        bus_b.ch_data    = {8'd160, 8'd3};
        bus_b.update_req = 1'b0;

        // Reset held for three edges with nonzero channel data.
        repeat (3) step();
        @(negedge clk);
        chk("reset_seg_a", 64'(bus_a.seg), 64'({28{1'b1}}));
        chk("reset_busy_a", 64'(bus_a.busy), 64'(0));
        chk("reset_done_a", 64'(bus_a.done), 64'(0));
        chk("reset_hb_a", 64'(bus_a.heartbeat), 64'(0));
        chk("reset_seg_b", 64'(bus_b.seg), 64'({28{1'b1}}));
        chk("reset_hb_b", 64'(bus_b.heartbeat), 64'(0));
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();

        // Plain refreshes, including overflow and digit boundaries.
        refresh_a(42, 7);
        refresh_a(255, 99);
        refresh_a(0, 100);
        refresh_a(9, 10);

        // Collision: requests at k, k+5, k+9; data changes from edge k+3.
        bus_a.ch_data    = {8'd7, 8'd42};
        bus_a.update_req = 1'b1;
        k = cyc + 1;
        q_a.push_back('{exp_seg(42, 7), k + LAT});
        step();
        bus_a.update_req = 1'b0;
        repeat (2) step();
        bus_a.ch_data = {8'd0, 8'd99};
        repeat (2) step();
        bus_a.update_req = 1'b1;
        q_a.push_back('{exp_seg(99, 0), k + 2 * LAT});
        step();
        bus_a.update_req = 1'b0;
        repeat (3) step();
        bus_a.update_req = 1'b1;
        step();
        bus_a.update_req = 1'b0;
        while (cyc < k + LAT) step();
        @(negedge clk);
        chk("collision_busy_held", 64'(bus_a.busy), 64'(1));
        while (cyc < k + 2 * LAT + 8) step();
        @(negedge clk);
        chk("collision_busy_cleared", 64'(bus_a.busy), 64'(0));

        // Reset sampled at k+10 of a refresh: no done may follow.
        bus_a.ch_data    = {8'd1, 8'd2};
        bus_a.update_req = 1'b1;
        k = cyc + 1;
        step();
        bus_a.update_req = 1'b0;
        while (cyc < k + 9) step();
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        @(negedge clk);
        chk("abort_seg", 64'(bus_a.seg), 64'({28{1'b1}}));
        chk("abort_busy", 64'(bus_a.busy), 64'(0));
        repeat (30) step();

        refresh_a(42, 7);

        while (cyc < END_CYC) step();
        chk("a_queue_drained", 64'(q_a.size()), 64'(0));
        chk("b_queue_drained", 64'(q_b.size()), 64'(0));
        chk("b_tick_count", 64'(hb_cnt), 64'((END_CYC - 3) / TICK_B));
        chk("b_done_count", 64'(done_b_cnt), 64'(hb_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
